// File: rtl/srambank_arbiter_2p.sv
// Two-port round-robin arbiter/sequencer in front of a single 1-cycle-read SRAM bank.
// Optional performance counters are enabled by defining SRAMARB_PERFCNT_EN.
module srambank_arbiter_2p #(
  parameter int AW = 10,
  parameter int DW = 48
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wd,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wd,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata,
  output logic          sram_banksel,
  output logic          sram_read,
  output logic          sram_write,
  output logic [AW-1:0] sram_address,
  output logic [DW-1:0] sram_wd,
`ifdef SRAMARB_PERFCNT_EN
  output logic [15:0]   perf_gnt0,
  output logic [15:0]   perf_gnt1,
  output logic [15:0]   perf_conflict,
`endif
  input  logic [DW-1:0] sram_dataout
);

  typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_e;

  logic  r_en;
  port_e r_last_grant;
  logic  r_rd_pend;
  port_e r_rd_tag;

  logic  w_gnt0;
  logic  w_gnt1;
  logic  w_we;

  // On contention the port that did not win last time gets the bank.
  always_comb begin
    w_gnt0 = r_en & req0_valid & (~req1_valid | (r_last_grant == PORT1));
    w_gnt1 = r_en & req1_valid & (~req0_valid | (r_last_grant == PORT0));
    w_we   = w_gnt0 ? req0_we : (w_gnt1 ? req1_we : 1'b0);
  end

  always_comb begin
    req0_ready   = w_gnt0;
    req1_ready   = w_gnt1;
    sram_banksel = w_gnt0 | w_gnt1;
    sram_write   = sram_banksel & w_we;
    sram_read    = sram_banksel & ~w_we;
    sram_address = '0;
    sram_wd      = '0;
    if (w_gnt0) begin
      sram_address = req0_addr;
      sram_wd      = req0_wd;
    end else if (w_gnt1) begin
      sram_address = req1_addr;
      sram_wd      = req1_wd;
    end
  end

  always_comb begin
    rsp0_valid = r_rd_pend & (r_rd_tag == PORT0);
    rsp1_valid = r_rd_pend & (r_rd_tag == PORT1);
    rsp0_rdata = rsp0_valid ? sram_dataout : '0;
    rsp1_rdata = rsp1_valid ? sram_dataout : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en         <= 1'b0;
      r_last_grant <= PORT1;
      r_rd_pend    <= 1'b0;
      r_rd_tag     <= PORT0;
    end else begin
      r_en      <= 1'b1;
      r_rd_pend <= sram_read;
      if (sram_banksel) begin
        r_last_grant <= w_gnt1 ? PORT1 : PORT0;
      end
      if (sram_read) begin
        r_rd_tag <= w_gnt1 ? PORT1 : PORT0;
      end
    end
  end

`ifdef SRAMARB_PERFCNT_EN
  logic [15:0] r_gnt0;
  logic [15:0] r_gnt1;
  logic [15:0] r_conflict;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt0     <= '0;
      r_gnt1     <= '0;
      r_conflict <= '0;
    end else begin
      if (w_gnt0 && (r_gnt0 != '1)) r_gnt0 <= r_gnt0 + 16'd1;
      if (w_gnt1 && (r_gnt1 != '1)) r_gnt1 <= r_gnt1 + 16'd1;
      if (r_en && req0_valid && req1_valid && (r_conflict != '1)) r_conflict <= r_conflict + 16'd1;
    end
  end

  always_comb begin
    perf_gnt0     = r_gnt0;
    perf_gnt1     = r_gnt1;
    perf_conflict = r_conflict;
  end
`endif

endmodule

// File: tb/tb_srambank_arbiter_2p.sv
// Scoreboard bench for srambank_arbiter_2p with a behavioural 1-cycle SRAM bank.
module tb_srambank_arbiter_2p;
  localparam int AW = 10;
  localparam int DW = 48;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req0_valid = 1'b0, req0_we = 1'b0, req1_valid = 1'b0, req1_we = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [DW-1:0] req0_wd = '0, req1_wd = '0;
  logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic          sram_banksel, sram_read, sram_write;
  logic [AW-1:0] sram_address;
  logic [DW-1:0] sram_wd;
  logic [DW-1:0] sram_dataout = '0;
`ifdef SRAMARB_PERFCNT_EN
  logic [15:0]   perf_gnt0, perf_gnt1, perf_conflict;
`endif

  srambank_arbiter_2p #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wd(req0_wd), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wd(req1_wd), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .sram_banksel(sram_banksel), .sram_read(sram_read), .sram_write(sram_write),
    .sram_address(sram_address), .sram_wd(sram_wd),
`ifdef SRAMARB_PERFCNT_EN
    .perf_gnt0(perf_gnt0), .perf_gnt1(perf_gnt1), .perf_conflict(perf_conflict),
`endif
    .sram_dataout(sram_dataout)
  );

  always #5 clk = ~clk;

  // Behavioural bank and an independent shadow copy used for expectations.
  logic [DW-1:0] mem    [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]    = {16'hC0DE, 22'h0, i[9:0]};
      shadow[i] = {16'hC0DE, 22'h0, i[9:0]};
    end
  end
  always @(posedge clk) begin
    if (sram_banksel && sram_write) mem[sram_address] <= sram_wd;
    if (sram_banksel && sram_read)  sram_dataout <= mem[sram_address];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_chk  = 0;
  int acc0 = 0, acc1 = 0, conf = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {logic port; logic [DW-1:0] data; int due;} exp_t;
  exp_t q[$];

  // Monitor: every cycle either exactly the expected response or no response.
  always @(negedge clk) begin
    if (reset_n) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("rsp0_valid", rsp0_valid, e.port == 1'b0);
        chk("rsp1_valid", rsp1_valid, e.port == 1'b1);
        chk("rsp_rdata", e.port ? rsp1_rdata : rsp0_rdata, e.data);
        chk("rsp_other_rdata", e.port ? rsp0_rdata : rsp1_rdata, 0);
      end else begin
        chk("rsp0_idle", rsp0_valid, 0);
        chk("rsp1_idle", rsp1_valid, 0);
      end
    end
  end

  // One issue cycle: drive, check grants against hand-computed values, record expectations.
  task automatic step(input logic v0, input logic we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic v1, input logic we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input logic e0, input logic e1);
    req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wd = d0;
    req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wd = d1;
    @(negedge clk);
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    if (v0 && v1 && (e0 || e1)) conf++;
    if (e0) begin
      acc0++;
      if (we0) shadow[a0] = d0;
      else q.push_back('{1'b0, shadow[a0], cyc + 1});
    end
    if (e1) begin
      acc1++;
      if (we1) shadow[a1] = d1;
      else q.push_back('{1'b1, shadow[a1], cyc + 1});
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                        sram_banksel, sram_read, sram_write}, 0);
    chk({tag, "_bus"}, {sram_address, rsp0_rdata | rsp1_rdata | sram_wd}, 0);
  endtask

  logic [AW-1:0] a0, a1;

  initial begin
    // Reset with a request already pending: nothing may leak out.
    req0_valid = 1'b1; req0_addr = 10'd5;
    repeat (2) @(posedge clk);
    #1 chk_all_zero("in_reset");
    reset_n = 1'b1;

    // First cycle after release: en still low.
    step(1, 0, 10'd5, '0, 0, 0, '0, '0, 0, 0);
    step(1, 0, 10'd5, '0, 0, 0, '0, '0, 1, 0);
    // Write then read-after-write from the other port.
    step(1, 1, 10'h3FF, 48'hA5A5_0000_FFFF, 0, 0, '0, '0, 1, 0);
    step(0, 0, '0, '0, 1, 0, 10'h3FF, '0, 0, 1);
    chk("raw_shadow", shadow[10'h3FF], 48'hA5A5_0000_FFFF);

    // Both ports reading continuously: strict alternation starting at port0.
    a0 = 10'd16; a1 = 10'd32;
    for (int i = 0; i < 8; i++) begin
      step(1, 0, a0, '0, 1, 0, a1, '0, (i % 2) == 0, (i % 2) == 1);
      if ((i % 2) == 0) a0 = a0 + 10'd1;
      else a1 = a1 + 10'd1;
    end

    // Only port1: granted every cycle.
    for (int i = 0; i < 4; i++)
      step(0, 0, '0, '0, 1, 0, 10'(100 + i), '0, 0, 1);

    // Mixed write/read contention with same-address ordering.
    step(1, 1, 10'd200, 48'h1234_5678_9ABC, 1, 0, 10'd200, '0, 1, 0);
    step(0, 0, '0, '0, 1, 0, 10'd200, '0, 0, 1);
    step(0, 0, '0, '0, 0, 0, '0, '0, 0, 0);

    // Reset pulsed during an accepted read cycle: the response must never appear.
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 10'd7;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_ready0", req0_ready, 1);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("mid_reset");
    q.delete();
    @(posedge clk); #1;
    chk_all_zero("held_reset");
    acc0 = 0; acc1 = 0; conf = 0;
    reset_n = 1'b1;
    step(1, 0, 10'd7, '0, 0, 0, '0, '0, 0, 0);
    step(1, 0, 10'd7, '0, 0, 0, '0, '0, 1, 0);
    step(0, 0, '0, '0, 0, 0, '0, '0, 0, 0);
    step(0, 0, '0, '0, 0, 0, '0, '0, 0, 0);

`ifdef SRAMARB_PERFCNT_EN
    chk("perf_gnt0", perf_gnt0, acc0);
    chk("perf_gnt1", perf_gnt1, acc1);
    chk("perf_conflict", perf_conflict, conf);
`endif

    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
